// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op-code constants and the per-bit gate evaluation helper.
// Rev 1.0 - initial release.
`default_nettype none

package logic_gate_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam int MAX_NIN = 8;

  // Evaluates one bit column: bit k of every operand, only the first nin are live.
  function automatic logic gate_eval(input logic [2:0] op,
                                     input logic [MAX_NIN-1:0] col,
                                     input int nin);
    logic w_and;
    logic w_or;
    logic w_xor;
    w_and = 1'b1;
    w_or  = 1'b0;
    w_xor = 1'b0;
    for (int i = 0; i < MAX_NIN; i++) begin
      if (i < nin) begin
        w_and = w_and & col[i];
        w_or  = w_or  | col[i];
        w_xor = w_xor ^ col[i];
      end
    end
    case (op)
      OP_NAND: return ~w_and;
      OP_AND:  return w_and;
      OP_OR:   return w_or;
      OP_NOR:  return ~w_or;
      OP_XOR:  return w_xor;
      OP_XNOR: return ~w_xor;
      OP_NOT:  return ~col[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_fifo.sv
// gate_fifo: DEPTH-entry result queue with a registered head word that holds after the last pop.
// Rev 1.0 - initial release.
`default_nettype none

module gate_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic [PW-1:0]    w_rnext;

  assign w_rnext = r_rptr + PW'(1);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_dout;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= w_rnext;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Head register: next stored entry, else the incoming word, else hold the last value.
      if (i_pop) begin
        if (r_count > CW'(1)) r_dout <= r_mem[w_rnext];
        else if (i_push)      r_dout <= i_data;
      end else if (i_push && (r_count == '0)) begin
        r_dout <= i_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: runtime-selected bitwise gate across NIN operands, queued valid/ready output.
// Optional pop/overflow counters via LOGIC_GATE_PIPE_STATS_EN. Rev 1.0 - initial release.
`default_nettype none

module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  input  logic                 err_clr
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  output logic [15:0]          result_cnt,
  output logic [7:0]           ovf_cnt
`endif
);

  logic [WIDTH-1:0] w_res;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             r_err;

  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    logic [MAX_NIN-1:0] w_col;
    for (genvar k = 0; k < MAX_NIN; k++) begin : g_op
      if (k < NIN) begin : g_used
        assign w_col[k] = in_data[k*WIDTH+j];
      end else begin : g_pad
        assign w_col[k] = 1'b0;
      end
    end
    assign w_res[j] = gate_eval(in_op, w_col, NIN);
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & ~w_full;
  assign w_pop     = ~w_empty & out_ready;
  assign out_err   = r_err;

  gate_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_res),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_err <= 1'b0;
    else if (w_push && (in_op == OP_RSVD)) r_err <= 1'b1;
    else if (err_clr)                      r_err <= 1'b0;
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] r_result_cnt;
  logic [7:0]  r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result_cnt <= '0;
      r_ovf_cnt    <= '0;
    end else begin
      if (w_pop) r_result_cnt <= r_result_cnt + 16'd1;
      if (in_valid && w_full && (r_ovf_cnt != 8'hFF)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign result_cnt = r_result_cnt;
  assign ovf_cnt    = r_ovf_cnt;
`endif

endmodule

`default_nettype wire
